// File: rtl/alu_exec_seq.sv
// alu_exec_seq -- RV32I execute-stage integer unit.
//
// Non-shift operations finish in one cycle. Shifts with a non-zero amount are
// done iteratively, SHIFT_STEP bits per cycle, so no full barrel shifter is
// needed.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready input handshake for operation, op_a, op_b
//   operation[3:0]    {funct7[5], funct3}
//   op_a, op_b        operands (shift amount = op_b[4:0])
//   out_valid/out_ready result handshake
//   result, zero      registered result and its zero flag
//   busy              unit is not idle
module alu_exec_seq #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      operation,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          state, state_nxt;
   logic [XLEN-1:0] sh_val;
   logic [5:0]      sh_rem;
   logic            sh_left;
   logic            sh_arith;

   logic [4:0]      shamt;
   logic            is_shift;
   logic            start_shift;
   logic            accept;
   logic [XLEN-1:0] alu_res;
   logic [5:0]      step;
   logic [5:0]      rem_nxt;
   logic [XLEN-1:0] sh_nxt;

   assign shamt       = op_b[4:0];
   assign is_shift    = (operation[1:0] == 2'b01);
   assign start_shift = is_shift && (shamt != 5'd0);

   // in_ready depends only on state and out_ready.
   assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   // Single-cycle result. Shifts only reach this path with shamt==0, where
   // the result is op_a unchanged.
   always_comb begin
      alu_res = '0;
      case (operation[2:0])
         3'b000: alu_res = operation[3] ? (op_a - op_b) : (op_a + op_b);
         3'b001: alu_res = op_a;
         3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         3'b011: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         3'b100: alu_res = op_a ^ op_b;
         3'b101: alu_res = op_a;
         3'b110: alu_res = op_a | op_b;
         3'b111: alu_res = op_a & op_b;
         default: alu_res = '0;
      endcase
   end

   // One shift step: k = min(SHIFT_STEP, remaining).
   always_comb begin
      step    = (sh_rem < 6'(SHIFT_STEP)) ? sh_rem : 6'(SHIFT_STEP);
      rem_nxt = sh_rem - step;
      if (sh_left)
         sh_nxt = sh_val << step;
      else if (sh_arith)
         sh_nxt = $signed(sh_val) >>> step;
      else
         sh_nxt = sh_val >> step;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (accept)
               state_nxt = start_shift ? SHIFT : DONE;
            else if ((state == DONE) && out_ready)
               state_nxt = IDLE;
         end
         SHIFT: begin
            if (rem_nxt == 6'd0)
               state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         result   <= '0;
         zero     <= 1'b0;
         sh_val   <= '0;
         sh_rem   <= '0;
         sh_left  <= 1'b0;
         sh_arith <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            if (start_shift) begin
               sh_val   <= op_a;
               sh_rem   <= {1'b0, shamt};
               sh_left  <= ~operation[2];
               sh_arith <= operation[3];
            end else begin
               result <= alu_res;
               zero   <= (alu_res == '0);
            end
         end else if (state == SHIFT) begin
            sh_val <= sh_nxt;
            sh_rem <= rem_nxt;
            if (rem_nxt == 6'd0) begin
               result <= sh_nxt;
               zero   <= (sh_nxt == '0);
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_seq.sv
module tb_alu_exec_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_valid4 = 1'b0;
   logic [3:0]  operation = '0;
   logic [31:0] op_a = '0, op_b = '0;
   logic        out_ready = 1'b1;

   logic        in_ready, out_valid, zero, busy;
   logic [31:0] result;
   logic        in_ready4, out_valid4, zero4, busy4;
   logic [31:0] result4;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   alu_exec_seq #(.XLEN(32), .SHIFT_STEP(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .operation(operation), .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .busy(busy));

   alu_exec_seq #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .operation(operation), .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid4), .out_ready(out_ready),
      .result(result4), .zero(zero4), .busy(busy4));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   // Issue one shift (or any op) and measure latency in cycles from the accept edge.
   task automatic run_op(input bit use4, input string name, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat);
      int lat;
      in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      operation = op; op_a = a; op_b = b;
      if (use4) in_valid4 = 1'b1; else in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_valid4 = 1'b0;
      op_a = 32'h5A5A_5A5A;   // inputs must be ignored while shifting
      lat = 1;
      while (!(use4 ? out_valid4 : out_valid) && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({name, "_lat"}, lat, exp_lat);
      chk({name, "_res"}, use4 ? result4 : result, exp);
      chk({name, "_zero"}, {31'b0, use4 ? zero4 : zero}, {31'b0, exp == 32'h0});
   endtask

   initial begin
      vecs[0]  = '{4'b0000, 32'd7,        32'd5,        32'd12};
      vecs[1]  = '{4'b1000, 32'd5,        32'd5,        32'd0};
      vecs[2]  = '{4'b0010, 32'hFFFFFFFF, 32'd1,        32'd1};
      vecs[3]  = '{4'b0011, 32'hFFFFFFFF, 32'd1,        32'd0};
      vecs[4]  = '{4'b0010, 32'd1,        32'hFFFFFFFF, 32'd0};
      vecs[5]  = '{4'b1011, 32'd1,        32'hFFFFFFFF, 32'd1};
      vecs[6]  = '{4'b0100, 32'h000000FF, 32'h0000000F, 32'h000000F0};
      vecs[7]  = '{4'b1110, 32'h000000F0, 32'h0000000F, 32'h000000FF};
      vecs[8]  = '{4'b0111, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000};
      vecs[9]  = '{4'b0000, 32'hFFFFFFFF, 32'd1,        32'd0};
      vecs[10] = '{4'b1000, 32'd0,        32'd1,        32'hFFFFFFFF};
      vecs[11] = '{4'b1111, 32'h0000FFFF, 32'h00000F0F, 32'h00000F0F};

      // Reset
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_result",    result,             32'd0);
      chk("rst_zero",      {31'b0, zero},      32'd0);
      chk("rst_busy",      {31'b0, busy},      32'd0);
      chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
      chk("rst_busy4",     {31'b0, busy4},     32'd0);

      // Back-to-back single-cycle ops, one per cycle
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         operation = vecs[i].op; op_a = vecs[i].a; op_b = vecs[i].b;
         in_valid = 1'b1;
         @(posedge clk); #1;
         chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
         chk($sformatf("vec%0d_res", i),   result,             vecs[i].exp);
         chk($sformatf("vec%0d_zero", i),  {31'b0, zero},      {31'b0, vecs[i].exp == 32'h0});
         chk($sformatf("vec%0d_rdy", i),   {31'b0, in_ready},  32'd1);
      end
      in_valid = 1'b0;

      // Iterative shifts, SHIFT_STEP=1
      run_op(1'b0, "sra31",  4'b1101, 32'h80000000, 32'd31,       32'hFFFFFFFF, 32);
      run_op(1'b0, "sll4",   4'b0001, 32'h00000001, 32'd4,        32'h00000010, 5);
      run_op(1'b0, "srl0",   4'b0101, 32'h80000000, 32'd0,        32'h80000000, 1);
      run_op(1'b0, "srl_hi", 4'b0101, 32'h80000000, 32'hFFFFFFE4, 32'h08000000, 5);
      run_op(1'b0, "sll_z",  4'b1001, 32'h80000000, 32'd1,        32'h00000000, 2);
      // SHIFT_STEP=4
      run_op(1'b1, "srl9_s4",  4'b0101, 32'hF0000000, 32'd9,  32'h00780000, 4);
      run_op(1'b1, "sra31_s4", 4'b1101, 32'h80000000, 32'd31, 32'hFFFFFFFF, 9);

      // Backpressure
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      operation = 4'b0100; op_a = 32'hFF; op_b = 32'h0F; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      operation = 4'b0000; op_a = 32'd3; op_b = 32'd4;   // held pending op
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp%0d_valid", c), {31'b0, out_valid}, 32'd1);
         chk($sformatf("bp%0d_res", c),   result,             32'h000000F0);
         chk($sformatf("bp%0d_rdy", c),   {31'b0, in_ready},  32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      chk("bp_rdy_release", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_new_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_new_res",   result,             32'd7);

      // Reset mid-shift
      @(posedge clk); #1;
      @(posedge clk); #1;
      operation = 4'b0001; op_a = 32'd1; op_b = 32'd20; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_busy",   {31'b0, busy},      32'd0);
      chk("mid_rst_valid",  {31'b0, out_valid}, 32'd0);
      chk("mid_rst_rdy",    {31'b0, in_ready},  32'd1);
      chk("mid_rst_result", result,             32'd0);
      begin
         int seen = 0;
         for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
         end
         chk("mid_rst_no_result", seen, 0);
      end
      operation = 4'b0000; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
      chk("post_rst_add",   result,             32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
